// File: rtl/fnd_pkg.sv
// Shared definitions for the 4-digit FND scan controller: segment fonts,
// common-line constants, buffer layout and slot-length helper.
package fnd_pkg;

    // Active-low fonts, bit order {dp,g,f,e,d,c,b,a}; dp off (bit7=1)
    localparam logic [7:0] FND_0     = 8'hc0;
    localparam logic [7:0] FND_1     = 8'hf9;
    localparam logic [7:0] FND_2     = 8'ha4;
    localparam logic [7:0] FND_3     = 8'hb0;
    localparam logic [7:0] FND_4     = 8'h99;
    localparam logic [7:0] FND_5     = 8'h92;
    localparam logic [7:0] FND_6     = 8'h82;
    localparam logic [7:0] FND_7     = 8'hf8;
    localparam logic [7:0] FND_8     = 8'h80;
    localparam logic [7:0] FND_9     = 8'h90;
    localparam logic [7:0] FND_DASH  = 8'hbf;
    localparam logic [7:0] FND_BLANK = 8'hff;

    localparam logic [3:0] COM_OFF   = 4'b1111;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  dp;
    } fnd_buf_t;

    function automatic int fnd_slot_cycles(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

endpackage

// File: rtl/fnd_digit_font.sv
// Combinational BCD-to-segment decoder with blanking and decimal point.
module fnd_digit_font
    import fnd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] font
);

    logic [7:0] base_s;

    // Glyph lookup; invalid BCD shows a dash, dp overrides even a blank digit
    always_comb begin
        base_s = FND_BLANK;
        if (blank) begin
            base_s = FND_BLANK;
        end else begin
            case (nibble)
                4'd0:    base_s = FND_0;
                4'd1:    base_s = FND_1;
                4'd2:    base_s = FND_2;
                4'd3:    base_s = FND_3;
                4'd4:    base_s = FND_4;
                4'd5:    base_s = FND_5;
                4'd6:    base_s = FND_6;
                4'd7:    base_s = FND_7;
                4'd8:    base_s = FND_8;
                4'd9:    base_s = FND_9;
                default: base_s = FND_DASH;
            endcase
        end
        if (dp) begin
            font = base_s & 8'h7f;
        end else begin
            font = base_s;
        end
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 4-digit common-anode FND driver with double-buffered
// BCD value, anti-ghost slot blanking and leading-zero blanking.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int P_CLK_HZ    = 100_000_000,
    parameter int P_SCAN_HZ   = 1_000,
    parameter int P_BLANK_CYC = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_bcd,
    input  logic [3:0]  i_dp,
    input  logic        i_lzb,
    input  logic        i_load,
    output logic [3:0]  o_fndCom,
    output logic [7:0]  o_fndFont,
    output logic        o_frame_done,
    output logic        o_pending
);

    localparam int P_SLOT = fnd_slot_cycles(P_CLK_HZ, P_SCAN_HZ);
    localparam int CNT_W  = (P_SLOT > 1) ? $clog2(P_SLOT) : 1;

    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       idx_r;
    fnd_buf_t         active_r;
    fnd_buf_t         shadow_r;
    logic             pending_r;

    logic             wrap_s;
    logic             boundary_s;
    logic             blank_phase_s;
    logic [3:0]       nib_s;
    logic             dp_s;
    logic             lzb_blank_s;
    logic [3:0]       com_s;
    logic [7:0]       font_s;

    assign wrap_s        = (cnt_r == CNT_W'(P_SLOT - 1));
    assign boundary_s    = wrap_s && (idx_r == 2'd3);
    assign blank_phase_s = (cnt_r < CNT_W'(P_BLANK_CYC));
    assign dp_s          = active_r.dp[idx_r];

    // Select the active digit nibble and its common line
    always_comb begin
        nib_s = 4'h0;
        com_s = COM_OFF;
        case (idx_r)
            2'd0: begin nib_s = active_r.bcd[3:0];   com_s = 4'b1110; end
            2'd1: begin nib_s = active_r.bcd[7:4];   com_s = 4'b1101; end
            2'd2: begin nib_s = active_r.bcd[11:8];  com_s = 4'b1011; end
            2'd3: begin nib_s = active_r.bcd[15:12]; com_s = 4'b0111; end
            default: begin nib_s = 4'h0; com_s = COM_OFF; end
        endcase
    end

    // A digit is a leading zero when it and every higher digit are zero
    always_comb begin
        lzb_blank_s = 1'b0;
        if (i_lzb) begin
            case (idx_r)
                2'd3:    lzb_blank_s = (active_r.bcd[15:12] == 4'h0);
                2'd2:    lzb_blank_s = (active_r.bcd[15:8] == 8'h00);
                2'd1:    lzb_blank_s = (active_r.bcd[15:4] == 12'h000);
                default: lzb_blank_s = 1'b0;
            endcase
        end else begin
            lzb_blank_s = 1'b0;
        end
    end

    fnd_digit_font u_font (
        .nibble (nib_s),
        .blank  (lzb_blank_s),
        .dp     (dp_s),
        .font   (font_s)
    );

    // Scan timing, double buffer swap at frame boundary, registered pin drive
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cnt_r        <= '0;
            idx_r        <= 2'd0;
            active_r     <= '0;
            shadow_r     <= '0;
            pending_r    <= 1'b0;
            o_fndCom     <= COM_OFF;
            o_fndFont    <= FND_BLANK;
            o_frame_done <= 1'b0;
            o_pending    <= 1'b0;
        end else begin
            if (wrap_s) begin
                cnt_r <= '0;
                idx_r <= idx_r + 2'd1;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end

            // Swap uses the pre-load shadow, so a boundary load waits a frame
            if (boundary_s && pending_r) begin
                active_r <= shadow_r;
            end

            if (i_load) begin
                shadow_r  <= '{bcd: i_bcd, dp: i_dp};
                pending_r <= 1'b1;
                o_pending <= 1'b1;
            end else if (boundary_s) begin
                pending_r <= 1'b0;
                o_pending <= 1'b0;
            end else begin
                o_pending <= pending_r;
            end

            if (blank_phase_s) begin
                o_fndCom  <= COM_OFF;
                o_fndFont <= FND_BLANK;
            end else begin
                o_fndCom  <= com_s;
                o_fndFont <= font_s;
            end

            o_frame_done <= boundary_s;
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench: reference model driven by elapsed-cycle arithmetic,
// table-driven display vectors and hand-written boundary/reset sequences.
module tb_fnd_scan_controller;

    localparam int SLOT  = 10;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        lzb;
    logic        load;
    logic [3:0]  com;
    logic [7:0]  font;
    logic        fd;
    logic        pend;

    always #5 clk = ~clk;

    fnd_scan_controller #(
        .P_CLK_HZ    (1000),
        .P_SCAN_HZ   (100),
        .P_BLANK_CYC (BLANK)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_bcd        (bcd),
        .i_dp         (dp),
        .i_lzb        (lzb),
        .i_load       (load),
        .o_fndCom     (com),
        .o_fndFont    (font),
        .o_frame_done (fd),
        .o_pending    (pend)
    );

    int checks = 0;
    int passes = 0;

    // Reference model: n = clock edges since reset release
    int          n = 0;
    logic [15:0] m_act_bcd, m_sh_bcd;
    logic [3:0]  m_act_dp, m_sh_dp;
    logic        m_pend;
    logic [7:0]  font_tbl [16];

    typedef struct {
        logic [15:0]      bcd;
        logic [3:0]       dp;
        logic             lzb;
        logic [3:0][7:0]  exp;   // exp[k] = expected font of digit k
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [7:0] exp_font_f(input logic [15:0] v, input logic [3:0] dps,
                                              input logic lz, input int d);
        logic [7:0] f;
        logic [3:0] nib;
        nib = v[4*d +: 4];
        if (lz && d > 0 && (v >> (4*d)) == 16'h0) f = 8'hff;
        else f = font_tbl[nib];
        if (dps[d]) f[7] = 1'b0;
        return f;
    endfunction

    // One clock: predict from pre-edge state, advance model, compare after edge
    task automatic tick();
        logic [3:0] e_com;
        logic [7:0] e_font;
        logic       e_fd;
        int p, d;
        bit bnd;
        if (!reset_n) begin
            n = 0;
            m_act_bcd = 16'h0; m_act_dp = 4'h0;
            m_sh_bcd = 16'h0;  m_sh_dp = 4'h0;
            m_pend = 1'b0;
            e_com = 4'hf; e_font = 8'hff; e_fd = 1'b0;
        end else begin
            n++;
            p = (n - 1) % SLOT;
            d = ((n - 1) / SLOT) % 4;
            if (p < BLANK) begin
                e_com = 4'hf; e_font = 8'hff;
            end else begin
                e_com = 4'hf;
                e_com[d] = 1'b0;
                e_font = exp_font_f(m_act_bcd, m_act_dp, lzb, d);
            end
            bnd = (n % FRAME) == 0;
            e_fd = bnd;
            if (bnd && m_pend) begin
                m_act_bcd = m_sh_bcd; m_act_dp = m_sh_dp;
            end
            if (load) begin
                m_sh_bcd = bcd; m_sh_dp = dp; m_pend = 1'b1;
            end else if (bnd) begin
                m_pend = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("model_com", 32'(com), 32'(e_com));
        check("model_font", 32'(font), 32'(e_font));
        check("model_frame_done", 32'(fd), 32'(e_fd));
        check("model_pending", 32'(pend), 32'(m_pend));
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bcd = v; dp = d; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Tick until o_frame_done is seen; a missing pulse counts as a failure
    task automatic wait_frame();
        int k;
        k = 0;
        while (fd !== 1'b1 && k < 2 * FRAME + 2) begin
            tick();
            k++;
        end
        check("frame_done_timeout", 32'(fd), 32'd1);
    endtask

    initial begin
        int first_fd;
        font_tbl = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
                     8'h80, 8'h90, 8'hbf, 8'hbf, 8'hbf, 8'hbf, 8'hbf, 8'hbf};
        vecs[0] = '{16'h1234, 4'b0100, 1'b0, {8'hf9, 8'h24, 8'hb0, 8'h99}};
        vecs[1] = '{16'h0070, 4'b0000, 1'b1, {8'hff, 8'hff, 8'hf8, 8'hc0}};
        vecs[2] = '{16'h0070, 4'b0000, 1'b0, {8'hc0, 8'hc0, 8'hf8, 8'hc0}};
        vecs[3] = '{16'h9a0b, 4'b0000, 1'b0, {8'h90, 8'hbf, 8'hc0, 8'hbf}};
        vecs[4] = '{16'h0000, 4'b1111, 1'b1, {8'h7f, 8'h7f, 8'h7f, 8'h40}};
        vecs[5] = '{16'h0005, 4'b0000, 1'b1, {8'hff, 8'hff, 8'hff, 8'h92}};

        reset_n = 1'b0; bcd = 16'h0; dp = 4'h0; lzb = 1'b0; load = 1'b0;

        // Reset state and first frame timing
        ticks(3);
        check("reset_com", 32'(com), 32'hf);
        check("reset_font", 32'(font), 32'hff);
        check("reset_pending", 32'(pend), 32'd0);
        reset_n = 1'b1;
        tick(); tick();
        check("first_blank_font", 32'(font), 32'hff);
        tick();
        check("digit0_com", 32'(com), 32'he);
        check("digit0_font", 32'(font), 32'hc0);
        first_fd = 0;
        for (int i = 4; i <= FRAME + 1; i++) begin
            tick();
            if (fd === 1'b1 && first_fd == 0) first_fd = i;
        end
        check("first_frame_done_cycle", 32'(first_fd), 32'(FRAME));

        // Table-driven display patterns
        foreach (vecs[v]) begin
            lzb = vecs[v].lzb;
            ticks(5);
            do_load(vecs[v].bcd, vecs[v].dp);
            check("load_pending", 32'(pend), 32'd1);
            wait_frame();
            ticks(BLANK + 1);
            for (int dg = 0; dg < 4; dg++) begin
                check($sformatf("vec%0d_digit%0d", v, dg), 32'(font), 32'(vecs[v].exp[dg]));
                if (dg < 3) ticks(SLOT);
            end
        end

        // Load on the boundary cycle itself
        lzb = 1'b0;
        do_load(16'h1111, 4'h0);
        begin
            int k;
            k = 0;
            while (((n + 1) % FRAME) != 0 && k < 2 * FRAME) begin tick(); k++; end
        end
        do_load(16'h2222, 4'h0);
        check("bnd_load_frame_done", 32'(fd), 32'd1);
        check("bnd_load_pending_kept", 32'(pend), 32'd1);
        ticks(BLANK + 1);
        check("bnd_load_shows_old", 32'(font), 32'hf9);
        wait_frame();
        check("bnd_load_pending_drop", 32'(pend), 32'd0);
        ticks(BLANK + 1);
        check("bnd_load_shows_new", 32'(font), 32'ha4);

        // Reset mid-frame with pending data
        ticks(SLOT + 3);
        do_load(16'h5678, 4'hf);
        check("pre_reset_pending", 32'(pend), 32'd1);
        reset_n = 1'b0;
        tick();
        check("midreset_com", 32'(com), 32'hf);
        check("midreset_font", 32'(font), 32'hff);
        check("midreset_pending", 32'(pend), 32'd0);
        reset_n = 1'b1;
        ticks(BLANK + 1);
        check("post_reset_digit0", 32'(font), 32'hc0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) bcd = 16'($urandom);
            else bcd = {4'($urandom_range(0, 9)) & {4{$urandom_range(0, 1) == 1}},
                        4'($urandom_range(0, 9)) & {4{$urandom_range(0, 1) == 1}},
                        4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            dp      = 4'($urandom);
            load    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 30) == 0) lzb = ~lzb;
            reset_n = ($urandom_range(0, 399) != 0);
            tick();
        end
        load = 1'b0; reset_n = 1'b1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
